poly_add_sub_seq: RTL and testbench

POLY_ADD_SUB_SEQ -- requirements
Module: poly_add_sub_seq

---
 rtl/poly_arith_pkg.sv | 20 ++
 rtl/mod_uni_add_sub.sv | 42 ++++
 rtl/poly_add_sub_seq.sv | 106 ++++++++++
 tb/tb_poly_add_sub_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/poly_arith_pkg.sv
// Shared parameters, coefficient type and modular helper for the polynomial arithmetic blocks.
package poly_arith_pkg;

    localparam int N       = 256;
    localparam int Q       = 3329;
    localparam int COEFF_W = 12;
    localparam int ADDR_W  = 8;

    typedef logic [COEFF_W-1:0] coeff_t;

    localparam logic [COEFF_W:0] Q_EXT = (COEFF_W+1)'(Q);

    // A single conditional subtraction suffices because callers keep x below 2*Q.
    function automatic coeff_t reduce_once(input logic [COEFF_W:0] x);
        logic [COEFF_W:0] y;
        y = (x >= Q_EXT) ? (x - Q_EXT) : x;
        return y[COEFF_W-1:0];
    endfunction

endpackage

// File: rtl/mod_uni_add_sub.sv
// Two-stage modular adder/subtractor mod Q: raw sum/difference, then one conditional reduction.
module mod_uni_add_sub
    import poly_arith_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_valid,
    input  logic   i_is_sub,
    input  coeff_t i_a,
    input  coeff_t i_b,
    output logic   o_valid,
    output coeff_t o_res
);

    logic [COEFF_W:0] w_raw;
    logic [COEFF_W:0] r_raw;
    logic             r_valid_s1;

    // Subtraction is biased by Q so the intermediate never goes negative.
    always_comb begin
        if (i_is_sub) begin
            w_raw = {1'b0, i_a} + Q_EXT - {1'b0, i_b};
        end else begin
            w_raw = {1'b0, i_a} + {1'b0, i_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_s1 <= 1'b0;
            r_raw      <= '0;
            o_valid    <= 1'b0;
            o_res      <= '0;
        end else begin
            r_valid_s1 <= i_valid;
            r_raw      <= w_raw;
            o_valid    <= r_valid_s1;
            o_res      <= reduce_once(r_raw);
        end
    end

endmodule

// File: rtl/poly_add_sub_seq.sv
// Streams A and B coefficient memories through one modular add/sub unit and writes
// the 256 results in index order, signalling completion with a one-cycle done pulse.
module poly_add_sub_seq
    import poly_arith_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              is_sub_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  coeff_t            a_rdata_i,
    input  coeff_t            b_rdata_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output coeff_t            wr_data_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    state_t            r_state;
    logic              r_is_sub;
    logic              r_rd_en_d1;
    logic [ADDR_W-1:0] r_addr_d1;
    logic [ADDR_W-1:0] r_addr_d2;

    // The address holds at the last index after RUN so the counter never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_is_sub  <= 1'b0;
            rd_en_o   <= 1'b0;
            rd_addr_o <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state   <= RUN;
                        r_is_sub  <= is_sub_i;
                        rd_en_o   <= 1'b1;
                        rd_addr_o <= '0;
                        busy_o    <= 1'b1;
                    end
                end
                RUN: begin
                    if (rd_addr_o == LAST_ADDR) begin
                        r_state <= DRAIN;
                        rd_en_o <= 1'b0;
                    end else begin
                        rd_addr_o <= rd_addr_o + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (wr_en_o && (wr_addr_o == LAST_ADDR)) begin
                        r_state <= DONE;
                        done_o  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Address and valid delay lines line up with the memory and datapath latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_en_d1 <= 1'b0;
            r_addr_d1  <= '0;
            r_addr_d2  <= '0;
            wr_addr_o  <= '0;
        end else begin
            r_rd_en_d1 <= rd_en_o;
            r_addr_d1  <= rd_addr_o;
            r_addr_d2  <= r_addr_d1;
            wr_addr_o  <= r_addr_d2;
        end
    end

    mod_uni_add_sub u_add_sub (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (r_rd_en_d1),
        .i_is_sub (r_is_sub),
        .i_a      (a_rdata_i),
        .i_b      (b_rdata_i),
        .o_valid  (wr_en_o),
        .o_res    (wr_data_o)
    );

endmodule

// File: tb/tb_poly_add_sub_seq.sv
// Randomised scoreboard bench for poly_add_sub_seq: expected writes are queued at each
// accepted start and a negedge monitor checks every output against a cycle schedule.
module tb_poly_add_sub_seq;
    import poly_arith_pkg::*;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              start_i  = 1'b0;
    logic              is_sub_i = 1'b0;
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    coeff_t            a_rdata_i = '0;
    coeff_t            b_rdata_i = '0;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    coeff_t            wr_data_o;
    logic              busy_o;
    logic              done_o;

    exp_t sbQ[$];
    int   memA[N];
    int   memB[N];
    int   cyc      = 0;
    int   runS     = 0;
    int   abortCyc = 0;
    bit   runValid = 1'b0;
    bit   monEn    = 1'b0;
    int   nVec     = 0;
    int   nErr     = 0;

    poly_add_sub_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .is_sub_i  (is_sub_i),
        .rd_en_o   (rd_en_o),
        .rd_addr_o (rd_addr_o),
        .a_rdata_i (a_rdata_i),
        .b_rdata_i (b_rdata_i),
        .wr_en_o   (wr_en_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Source memories with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en_o === 1'b1) begin
            a_rdata_i <= coeff_t'(memA[rd_addr_o]);
            b_rdata_i <= coeff_t'(memB[rd_addr_o]);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: control outputs follow a schedule relative to the accepted start; each write pops the scoreboard.
    always @(negedge clk) begin
        int   c;
        bit   act;
        exp_t e;
        if (monEn) begin
            c   = cyc;
            act = runValid && (c > runS) && (c <= runS + 260) && (c <= abortCyc);
            checkOutput("rd_en", rd_en_o, act && (c <= runS + 256));
            if (act && (c <= runS + 256)) checkOutput("rd_addr", rd_addr_o, c - runS - 1);
            checkOutput("wr_en", wr_en_o, act && (c >= runS + 4) && (c <= runS + 259));
            checkOutput("busy", busy_o, act);
            checkOutput("done", done_o, act && (c == runS + 260));
            if (wr_en_o === 1'b1) begin
                if (sbQ.size() == 0) begin
                    nVec++;
                    nErr++;
                    $display("[TB] FAIL unexpected_write at cycle %0d: got addr %0d, expected no write", c, wr_addr_o);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("wr_addr", wr_addr_o, e.addr);
                    checkOutput("wr_data", wr_data_o, e.data);
                    checkOutput("wr_cycle", c, e.cyc);
                end
            end
        end
    end

    // mode 0: all 3328, 1: all zero, 2: A=5 B=10, 3: A=i B=255-i, 4: random
    task automatic fillMem(input int mode);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       begin memA[i] = Q - 1; memB[i] = Q - 1; end
                1:       begin memA[i] = 0;     memB[i] = 0;     end
                2:       begin memA[i] = 5;     memB[i] = 10;    end
                3:       begin memA[i] = i;     memB[i] = 255 - i; end
                default: begin
                    memA[i] = int'($urandom_range(Q - 1, 0));
                    memB[i] = int'($urandom_range(Q - 1, 0));
                end
            endcase
        end
    endtask

    // Called just after a rising edge; start_i is high for exactly this cycle.
    task automatic applyStimulus(input bit sub);
        exp_t e;
        start_i  = 1'b1;
        is_sub_i = sub;
        runS     = cyc;
        abortCyc = 32'h7fff_ffff;
        runValid = 1'b1;
        for (int i = 0; i < N; i++) begin
            e.addr = i;
            e.data = sub ? ((((memA[i] - memB[i]) % Q) + Q) % Q) : ((memA[i] + memB[i]) % Q);
            e.cyc  = runS + 4 + i;
            sbQ.push_back(e);
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic runBody(input bit sub, input bit toggle, input bit extraStarts);
        while (cyc < runS + 261) begin
            @(posedge clk);
            #1;
            start_i = extraStarts && ((cyc == runS + 10) || (cyc == runS + 260));
            if (start_i) is_sub_i = ~sub;
            else if (toggle) is_sub_i = ~is_sub_i;
        end
        start_i = 1'b0;
    endtask

    task automatic resetMidRun();
        while (cyc < runS + 100) begin
            @(posedge clk);
            #1;
        end
        rst      = 1'b1;
        abortCyc = runS + 100;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbQ.delete();
        @(negedge clk);
        checkOutput("abort_rd_addr", rd_addr_o, 0);
        checkOutput("abort_wr_addr", wr_addr_o, 0);
        checkOutput("abort_wr_data", wr_data_o, 0);
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        monEn = 1'b1;
        @(negedge clk);
        checkOutput("reset_rd_addr", rd_addr_o, 0);
        checkOutput("reset_wr_addr", wr_addr_o, 0);
        checkOutput("reset_wr_data", wr_data_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        fillMem(0); applyStimulus(1'b0); runBody(1'b0, 1'b0, 1'b0);
        fillMem(1); applyStimulus(1'b1); runBody(1'b1, 1'b0, 1'b0);
        fillMem(2); applyStimulus(1'b1); runBody(1'b1, 1'b0, 1'b0);
        fillMem(3); applyStimulus(1'b1); runBody(1'b1, 1'b0, 1'b0);
        fillMem(4); applyStimulus(1'b0); runBody(1'b0, 1'b0, 1'b1);
        fillMem(4); applyStimulus(1'b1); runBody(1'b1, 1'b1, 1'b0);
        fillMem(4); applyStimulus(1'b0); runBody(1'b0, 1'b1, 1'b0);
        fillMem(4); applyStimulus(1'b0); resetMidRun();
        fillMem(4); applyStimulus(1'b1); runBody(1'b1, 1'b0, 1'b0);

        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("scoreboard_empty", sbQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
